// File: rtl/calc2_req_scheduler_if.sv
// Request/response handshake bundle for the calc2 front-end scheduler.
// master = requester/consumer side, slave = scheduler side.
interface calc2_req_scheduler_if #(
  parameter int ID_W   = 8,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_cmd;
  logic [DATA_W-1:0] req_op1;
  logic [DATA_W-1:0] req_op2;
  logic [ID_W-1:0]   req_id;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_code;
  logic [DATA_W-1:0] rsp_data;
  logic [ID_W-1:0]   rsp_id;
  logic [1:0]        rsp_port;

  modport master (
    output req_valid, req_cmd, req_op1,
    output req_op2, req_id, rsp_ready,
    input  req_ready, rsp_valid, rsp_code,
    input  rsp_data, rsp_id, rsp_port
  );

  modport slave (
    input  req_valid, req_cmd, req_op1,
    input  req_op2, req_id, rsp_ready,
    output req_ready, rsp_valid, rsp_code,
    output rsp_data, rsp_id, rsp_port
  );
endinterface

// File: rtl/calc2_req_scheduler.sv
// Round-robin request scheduler for the four-port calc2 core:
// tag allocation, two-cycle command issue, tagged response merge.
module calc2_req_scheduler #(
  parameter int ID_W   = 8,
  parameter int DATA_W = 32
) (
  input  logic              c_clk,
  input  logic              reset,
  calc2_req_scheduler_if.slave bus,
  output logic [3:0]        calc_cmd_out  [1:4],
  output logic [DATA_W-1:0] calc_data_out [1:4],
  output logic [1:0]        calc_tag_out  [1:4],
  input  logic [1:0]        calc_resp_in  [1:4],
  input  logic [DATA_W-1:0] calc_data_in  [1:4],
  input  logic [1:0]        calc_tag_in   [1:4],
  output logic              busy,
  output logic              err_spurious
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_OP2  = 1'b1;

  localparam logic [1:0] T_FREE   = 2'd0;
  localparam logic [1:0] T_ISSUED = 2'd1;
  localparam logic [1:0] T_QUEUED = 2'd2;

  typedef logic [DATA_W-1:0] data_t;

  logic [1:0]      tst_q   [4][4];
  logic [1:0]      tst_d   [4][4];
  logic [ID_W-1:0] idt_q   [4][4];
  logic [ID_W-1:0] idt_d   [4][4];

  logic [0:0]      ist_q   [4];
  logic [0:0]      ist_d   [4];
  logic [3:0]      cmd_q   [4];
  logic [3:0]      cmd_d   [4];
  data_t           dat_q   [4];
  data_t           dat_d   [4];
  data_t           op2_q   [4];
  data_t           op2_d   [4];
  logic [1:0]      otag_q  [4];
  logic [1:0]      otag_d  [4];

  logic [1:0]      fcode_q [4][4];
  logic [1:0]      fcode_d [4][4];
  data_t           fdata_q [4][4];
  data_t           fdata_d [4][4];
  logic [1:0]      ftg_q   [4][4];
  logic [1:0]      ftg_d   [4][4];
  logic [1:0]      wp_q    [4];
  logic [1:0]      wp_d    [4];
  logic [1:0]      rp_q    [4];
  logic [1:0]      rp_d    [4];
  logic [2:0]      cnt_q   [4];
  logic [2:0]      cnt_d   [4];

  logic [1:0]      iptr_q, iptr_d;
  logic [1:0]      optr_q, optr_d;
  logic            lock_q, lock_d;
  logic [1:0]      lport_q, lport_d;
  logic            err_q, err_d;

  logic [3:0]      elig;
  logic [3:0]      nonempty;
  logic [1:0]      ftag [4];
  logic [1:0]      gin;
  logic [1:0]      gout;
  logic            disp;
  logic            pop;
  logic [3:0]      push;
  logic [3:0]      popv;

  // lowest FREE tag per port; port eligible if idle next cycle
  always_comb begin : elig_c
    for (int p = 0; p < 4; p++) begin
      ftag[p]     = 2'd0;
      elig[p]     = 1'b0;
      nonempty[p] = cnt_q[p] != 3'd0;
      for (int t = 3; t >= 0; t--) begin
        if (tst_q[p][t] == T_FREE) begin
          ftag[p] = 2'(t);
          elig[p] = ist_q[p] == S_IDLE;
        end
      end
    end
  end

  always_comb begin : arb_c
    gin  = iptr_q;
    gout = optr_q;
    for (int k = 3; k >= 0; k--) begin
      if (elig[iptr_q + 2'(k)])
        gin = iptr_q + 2'(k);
      if (nonempty[optr_q + 2'(k)])
        gout = optr_q + 2'(k);
    end
    // a stalled response keeps its port until taken
    if (lock_q)
      gout = lport_q;
  end

  always_comb begin : hs_c
    bus.req_ready = !reset && (|elig);
    disp = bus.req_valid && bus.req_ready
        && (bus.req_cmd != 4'd0);
    bus.rsp_valid = |nonempty;
    pop = bus.rsp_valid && bus.rsp_ready;
  end

  always_comb begin : rsp_c
    bus.rsp_code = '0;
    bus.rsp_data = '0;
    bus.rsp_id   = '0;
    bus.rsp_port = '0;
    if (bus.rsp_valid) begin
      bus.rsp_code = fcode_q[gout][rp_q[gout]];
      bus.rsp_data = fdata_q[gout][rp_q[gout]];
      bus.rsp_id   = idt_q[gout][ftg_q[gout][rp_q[gout]]];
      bus.rsp_port = gout;
    end
  end

  always_comb begin : next_c
    tst_d   = tst_q;
    idt_d   = idt_q;
    op2_d   = op2_q;
    fcode_d = fcode_q;
    fdata_d = fdata_q;
    ftg_d   = ftg_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    iptr_d  = iptr_q;
    optr_d  = optr_q;
    push    = '0;
    popv    = '0;
    err_d   = 1'b0;
    lock_d  = bus.rsp_valid && !bus.rsp_ready;
    lport_d = gout;

    for (int p = 0; p < 4; p++) begin
      cmd_d[p]  = '0;
      dat_d[p]  = '0;
      otag_d[p] = '0;
      ist_d[p]  = S_IDLE;
      if (ist_q[p] == S_OP2)
        dat_d[p] = op2_q[p];
    end

    if (disp) begin
      cmd_d[gin]  = bus.req_cmd;
      dat_d[gin]  = bus.req_op1;
      otag_d[gin] = ftag[gin];
      op2_d[gin]  = bus.req_op2;
      ist_d[gin]  = S_OP2;
      tst_d[gin][ftag[gin]] = T_ISSUED;
      idt_d[gin][ftag[gin]] = bus.req_id;
      iptr_d = gin + 2'd1;
    end

    for (int n = 0; n < 4; n++) begin
      if (calc_resp_in[n+1] != 2'd0) begin
        if (tst_q[n][calc_tag_in[n+1]] == T_ISSUED) begin
          fcode_d[n][wp_q[n]] = calc_resp_in[n+1];
          fdata_d[n][wp_q[n]] = calc_data_in[n+1];
          ftg_d[n][wp_q[n]]   = calc_tag_in[n+1];
          wp_d[n]  = wp_q[n] + 2'd1;
          push[n]  = 1'b1;
          tst_d[n][calc_tag_in[n+1]] = T_QUEUED;
        end else begin
          err_d = 1'b1;
        end
      end
    end

    if (pop) begin
      rp_d[gout] = rp_q[gout] + 2'd1;
      popv[gout] = 1'b1;
      tst_d[gout][ftg_q[gout][rp_q[gout]]] = T_FREE;
      optr_d = gout + 2'd1;
    end

    for (int p = 0; p < 4; p++)
      cnt_d[p] = cnt_q[p] + 3'(push[p]) - 3'(popv[p]);
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      tst_q   <= '{default: '{default: T_FREE}};
      idt_q   <= '{default: '{default: '0}};
      ist_q   <= '{default: S_IDLE};
      cmd_q   <= '{default: '0};
      dat_q   <= '{default: '0};
      op2_q   <= '{default: '0};
      otag_q  <= '{default: '0};
      fcode_q <= '{default: '{default: '0}};
      fdata_q <= '{default: '{default: '0}};
      ftg_q   <= '{default: '{default: '0}};
      wp_q    <= '{default: '0};
      rp_q    <= '{default: '0};
      cnt_q   <= '{default: '0};
      iptr_q  <= '0;
      optr_q  <= '0;
      lock_q  <= 1'b0;
      lport_q <= '0;
      err_q   <= 1'b0;
    end else begin
      tst_q   <= tst_d;
      idt_q   <= idt_d;
      ist_q   <= ist_d;
      cmd_q   <= cmd_d;
      dat_q   <= dat_d;
      op2_q   <= op2_d;
      otag_q  <= otag_d;
      fcode_q <= fcode_d;
      fdata_q <= fdata_d;
      ftg_q   <= ftg_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      iptr_q  <= iptr_d;
      optr_q  <= optr_d;
      lock_q  <= lock_d;
      lport_q <= lport_d;
      err_q   <= err_d;
    end
  end

  always_comb begin : out_c
    busy = 1'b0;
    for (int p = 0; p < 4; p++) begin
      calc_cmd_out[p+1]  = cmd_q[p];
      calc_data_out[p+1] = dat_q[p];
      calc_tag_out[p+1]  = otag_q[p];
      for (int t = 0; t < 4; t++)
        busy = busy | (tst_q[p][t] != T_FREE);
    end
    err_spurious = err_q;
  end

endmodule

// File: tb/tb_calc2_req_scheduler.sv
// Scoreboard bench for calc2_req_scheduler with a behavioural
// calc2 core model, directed scenarios and a randomized phase.
module tb_calc2_req_scheduler;
  localparam int ID_W   = 8;
  localparam int DATA_W = 32;

  logic c_clk = 1'b0;
  logic reset = 1'b1;
  always #5 c_clk = ~c_clk;

  calc2_req_scheduler_if #(.ID_W(ID_W), .DATA_W(DATA_W)) bus();

  logic [3:0]  calc_cmd_out  [1:4];
  logic [31:0] calc_data_out [1:4];
  logic [1:0]  calc_tag_out  [1:4];
  logic [1:0]  calc_resp_in  [1:4];
  logic [31:0] calc_data_in  [1:4];
  logic [1:0]  calc_tag_in   [1:4];
  logic        busy;
  logic        err_spurious;

  calc2_req_scheduler #(.ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .bus          (bus),
    .calc_cmd_out (calc_cmd_out),
    .calc_data_out(calc_data_out),
    .calc_tag_out (calc_tag_out),
    .calc_resp_in (calc_resp_in),
    .calc_data_in (calc_data_in),
    .calc_tag_in  (calc_tag_in),
    .busy         (busy),
    .err_spurious (err_spurious)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0]  id;
    logic [1:0]  code;
    logic [31:0] data;
  } exp_t;
  typedef struct {
    logic [7:0] id;
    logic [1:0] port;
  } log_t;
  typedef struct {
    int          port;
    logic [3:0]  cmd;
    logic [31:0] op1;
    int          cyc;
  } cl_t;
  typedef struct {
    logic [1:0]  code;
    logic [31:0] data;
    logic [1:0]  tag;
    int          rdy;
  } pr_t;

  exp_t sb[$];
  log_t rlog[$];
  cl_t  clog[$];
  pr_t  pq[1:4][$];

  int cyc = 0;
  int flush_seq = 0, flush_done = 0;
  int inj_seq = 0, inj_done = 0;
  int inj_port = 2;
  logic [1:0] inj_tag = 2'd0;
  int rel_mode = 0;
  int rdy_mode = 1;
  bit chk_no_err = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void calc_fn(input logic [3:0] c,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [1:0] code,
                                  output logic [31:0] r);
    code = 2'd1;
    case (c)
      4'd1: r = a + b;
      4'd2: r = a - b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      default: begin code = 2'd2; r = '0; end
    endcase
  endfunction

  // calc2 core model: takes cmd/op1 then op2, answers later per port
  logic        pend [1:4];
  logic [3:0]  pcmd [1:4];
  logic [31:0] pop1 [1:4];
  logic [1:0]  ptag [1:4];
  pr_t         me;

  initial begin : model
    for (int p = 1; p <= 4; p++) begin
      calc_resp_in[p] = '0;
      calc_data_in[p] = '0;
      calc_tag_in[p]  = '0;
      pend[p] = 1'b0;
    end
    forever begin
      @(negedge c_clk);
      cyc++;
      if (flush_done != flush_seq) begin
        flush_done = flush_seq;
        for (int p = 1; p <= 4; p++) begin
          pq[p].delete();
          pend[p] = 1'b0;
        end
      end
      for (int p = 1; p <= 4; p++) begin
        if (pend[p]) begin
          calc_fn(pcmd[p], pop1[p], calc_data_out[p], me.code, me.data);
          me.tag = ptag[p];
          me.rdy = cyc + int'($urandom_range(0, 5));
          pq[p].push_back(me);
          pend[p] = 1'b0;
        end else if (calc_cmd_out[p] != 4'd0) begin
          pcmd[p] = calc_cmd_out[p];
          pop1[p] = calc_data_out[p];
          ptag[p] = calc_tag_out[p];
          pend[p] = 1'b1;
          clog.push_back('{p, calc_cmd_out[p], calc_data_out[p], cyc});
        end
      end
      for (int p = 1; p <= 4; p++) begin
        calc_resp_in[p] = '0;
        calc_data_in[p] = '0;
        calc_tag_in[p]  = '0;
        if (inj_done != inj_seq && p == inj_port) begin
          calc_resp_in[p] = 2'd1;
          calc_data_in[p] = 32'hdead;
          calc_tag_in[p]  = inj_tag;
        end else if (rel_mode != 1 && pq[p].size() > 0 &&
                     (rel_mode == 2 ||
                      (pq[p][0].rdy <= cyc && $urandom_range(0, 1) == 1))) begin
          calc_resp_in[p] = pq[p][0].code;
          calc_data_in[p] = pq[p][0].data;
          calc_tag_in[p]  = pq[p][0].tag;
          void'(pq[p].pop_front());
        end
      end
      inj_done = inj_seq;
    end
  end

  initial begin : rdy_drv
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge c_clk);
      #1;
      case (rdy_mode)
        0:       bus.rsp_ready = 1'b0;
        1:       bus.rsp_ready = 1'b1;
        default: bus.rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor: pops scoreboard on every response handshake
  logic        ps = 1'b0;
  logic [7:0]  s_id;
  logic [1:0]  s_code, s_port;
  logic [31:0] s_data;
  int          fidx;

  initial begin : monitor
    forever begin
      @(negedge c_clk);
      if (!reset && ps) begin
        tests++;
        if (!(bus.rsp_valid && bus.rsp_id == s_id && bus.rsp_data == s_data &&
              bus.rsp_code == s_code && bus.rsp_port == s_port)) begin
          fails++;
          $display("FAIL rsp_stable: got v=%0b id=%0h d=%0h required id=%0h d=%0h",
                   bus.rsp_valid, bus.rsp_id, bus.rsp_data, s_id, s_data);
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        fidx = -1;
        foreach (sb[i]) if (fidx < 0 && sb[i].id == bus.rsp_id) fidx = i;
        tests++;
        if (fidx < 0) begin
          fails++;
          $display("FAIL rsp_unexpected: got id %0h, required none outstanding",
                   bus.rsp_id);
        end else begin
          if (bus.rsp_code !== sb[fidx].code || bus.rsp_data !== sb[fidx].data) begin
            fails++;
            $display("FAIL rsp_data id %0h: got code %0d data %0h required code %0d data %0h",
                     bus.rsp_id, bus.rsp_code, bus.rsp_data,
                     sb[fidx].code, sb[fidx].data);
          end
          sb.delete(fidx);
        end
        rlog.push_back('{bus.rsp_id, bus.rsp_port});
      end
      if (chk_no_err)
        check("no_spurious", 64'(err_spurious), 64'd0);
      ps     = !reset && bus.rsp_valid && !bus.rsp_ready;
      s_id   = bus.rsp_id;
      s_code = bus.rsp_code;
      s_data = bus.rsp_data;
      s_port = bus.rsp_port;
    end
  end

  task automatic send(input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] b, input logic [7:0] id);
    int n;
    logic ok;
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_cmd   = c;
    bus.req_op1   = a;
    bus.req_op2   = b;
    bus.req_id    = id;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge c_clk);
      ok = bus.req_ready;
      n++;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL req_timeout: got req_ready 0 for id %0h, required 1", id);
      bus.req_valid = 1'b0;
      return;
    end
    if (c != 4'd0) begin
      e.id = id;
      calc_fn(c, a, b, e.code, e.data);
      sb.push_back(e);
    end
    @(posedge c_clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while ((sb.size() != 0 || bus.rsp_valid) && n < maxc) begin
      @(negedge c_clk);
      n++;
    end
    check("drain_outstanding", 64'(sb.size()), 64'd0);
    @(posedge c_clk);
    #1;
  endtask

  task automatic do_reset();
    logic anyo;
    reset = 1'b1;
    @(negedge c_clk);
    check("ready_in_reset", 64'(bus.req_ready), 64'd0);
    @(posedge c_clk); #1;
    @(posedge c_clk); #1;
    flush_seq++;
    sb.delete();
    rlog.delete();
    clog.delete();
    @(negedge c_clk);
    @(posedge c_clk); #1;
    reset = 1'b0;
    @(negedge c_clk);
    anyo = 1'b0;
    for (int p = 1; p <= 4; p++)
      anyo = anyo | (|calc_cmd_out[p]) | (|calc_data_out[p]) | (|calc_tag_out[p]);
    check("ready_after_reset", 64'(bus.req_ready), 64'd1);
    check("busy_after_reset", 64'(busy), 64'd0);
    check("rsp_valid_after_reset", 64'(bus.rsp_valid), 64'd0);
    check("calc_out_after_reset", 64'(anyo), 64'd0);
    check("err_after_reset", 64'(err_spurious), 64'd0);
    @(posedge c_clk); #1;
  endtask

  logic [3:0] cmds [8];
  int   cnt_e, cnt_v;
  logic anyo;

  initial begin : main
    cmds = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd0, 4'd3, 4'd9, 4'd15};
    bus.req_valid = 1'b0;
    bus.req_cmd   = '0;
    bus.req_op1   = '0;
    bus.req_op2   = '0;
    bus.req_id    = '0;

    // single add
    rdy_mode = 1;
    do_reset();
    chk_no_err = 1;
    send(4'd1, 32'd3, 32'd4, 8'h11);
    @(negedge c_clk);
    check("t1_cmd_cyc1", 64'(calc_cmd_out[1]), 64'd1);
    check("t1_data_cyc1", 64'(calc_data_out[1]), 64'd3);
    check("t1_tag_cyc1", 64'(calc_tag_out[1]), 64'd0);
    check("t1_port2_idle", 64'(calc_cmd_out[2]), 64'd0);
    @(negedge c_clk);
    check("t1_cmd_cyc2", 64'(calc_cmd_out[1]), 64'd0);
    check("t1_data_cyc2", 64'(calc_data_out[1]), 64'd4);
    @(posedge c_clk); #1;
    wait_drain(100);
    check("t1_rsp_count", 64'(rlog.size()), 64'd1);
    if (rlog.size() == 1) begin
      check("t1_rsp_id", 64'(rlog[0].id), 64'h11);
      check("t1_rsp_port", 64'(rlog[0].port), 64'd0);
    end

    // four back-to-back requests
    do_reset();
    for (int i = 0; i < 4; i++)
      send(4'd1, 32'(10 * (i + 1)), 32'(i), 8'(i + 1));
    wait_drain(200);
    check("t2_cmd_count", 64'(clog.size()), 64'd4);
    if (clog.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t2_port", 64'(clog[i].port), 64'(i + 1));
        check("t2_op1", 64'(clog[i].op1), 64'(10 * (i + 1)));
        check("t2_cycle", 64'(clog[i].cyc - clog[0].cyc), 64'(i));
      end
    end
    check("t2_rsp_count", 64'(rlog.size()), 64'd4);

    // discarded command 0
    do_reset();
    send(4'd0, 32'd1, 32'd2, 8'h55);
    repeat (6) @(negedge c_clk);
    check("t0_no_traffic", 64'(clog.size()), 64'd0);
    check("t0_no_busy", 64'(busy), 64'd0);
    check("t0_no_rsp", 64'(rlog.size()), 64'd0);
    @(posedge c_clk); #1;

    // fill all 16 tags with responses blocked
    rdy_mode = 0;
    do_reset();
    for (int i = 0; i < 16; i++)
      send(4'd2, $urandom, $urandom, 8'(32 + i));
    @(negedge c_clk);
    check("t3_ready_full", 64'(bus.req_ready), 64'd0);
    check("t3_busy_full", 64'(busy), 64'd1);
    repeat (12) @(negedge c_clk);
    check("t3_ready_held", 64'(bus.req_ready), 64'd0);
    @(posedge c_clk); #1;
    rdy_mode = 1;
    wait_drain(400);
    @(negedge c_clk);
    check("t3_ready_drained", 64'(bus.req_ready), 64'd1);
    check("t3_busy_drained", 64'(busy), 64'd0);
    check("t3_rsp_count", 64'(rlog.size()), 64'd16);
    @(posedge c_clk); #1;

    // simultaneous responses on all four ports
    rel_mode = 1;
    do_reset();
    for (int i = 0; i < 4; i++)
      send(4'd5, 32'(i + 1), 32'(i + 2), 8'(8'h41 + i));
    repeat (6) @(negedge c_clk);
    @(posedge c_clk); #1;
    rel_mode = 2;
    wait_drain(100);
    rel_mode = 0;
    check("t4_rsp_count", 64'(rlog.size()), 64'd4);
    if (rlog.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t4_order_port", 64'(rlog[i].port), 64'(i));
        check("t4_order_id", 64'(rlog[i].id), 64'(8'h41 + i));
      end
    end

    // spurious response on a FREE tag
    do_reset();
    chk_no_err = 0;
    inj_port = 2;
    inj_tag  = 2'd1;
    inj_seq++;
    @(negedge c_clk);
    cnt_e = 0;
    cnt_v = 0;
    repeat (5) begin
      @(negedge c_clk);
      if (err_spurious) cnt_e++;
      if (bus.rsp_valid) cnt_v++;
    end
    check("t5_spur_pulses", 64'(cnt_e), 64'd1);
    check("t5_no_rsp", 64'(cnt_v), 64'd0);
    @(posedge c_clk); #1;

    // reset between command and operand-2 cycles
    rel_mode = 2;
    do_reset();
    send(4'd1, 32'd5, 32'd6, 8'h77);
    reset = 1'b1;
    @(posedge c_clk); #1;
    reset = 1'b0;
    sb.delete();
    @(negedge c_clk);
    anyo = 1'b0;
    for (int p = 1; p <= 4; p++)
      anyo = anyo | (|calc_cmd_out[p]) | (|calc_data_out[p]) | (|calc_tag_out[p]);
    check("t6_calc_out_cleared", 64'(anyo), 64'd0);
    check("t6_busy_cleared", 64'(busy), 64'd0);
    cnt_e = 0;
    cnt_v = 0;
    repeat (8) begin
      @(negedge c_clk);
      if (err_spurious) cnt_e++;
      if (bus.rsp_valid) cnt_v++;
    end
    check("t6_stale_spurious", 64'(cnt_e), 64'd1);
    check("t6_no_rsp", 64'(cnt_v), 64'd0);
    @(posedge c_clk); #1;
    rel_mode = 0;

    // randomized traffic with random backpressure
    rdy_mode = 2;
    do_reset();
    chk_no_err = 1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge c_clk); #1;
      end
      send(cmds[$urandom_range(0, 7)], $urandom, $urandom, 8'(i));
    end
    wait_drain(3000);
    @(negedge c_clk);
    check("t7_busy_end", 64'(busy), 64'd0);
    chk_no_err = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/calc2_req_scheduler.md
# calc2_req_scheduler

Front-end controller for the four-port calc2 calculator core. It accepts a single stream of operation requests and spreads them round-robin over calc2 ports 1-4. It allocates the 2-bit calc2 tags, drives the two-cycle calc2 command/operand sequence, and matches tagged responses back to requester IDs. Completed results are merged into one valid/ready response stream.

## Interface
- ID_W, 8, width of requester ID carried from request to response
- DATA_W, 32, operand/result width; fixed to calc2 data width
- c_clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- req_valid / req_ready  in / out  1 / 1  request handshake
- req_cmd  in  4  calc2 command (1 add, 2 sub, 5 shl, 6 shr; others forwarded unchanged except 0)
- req_op1, req_op2  in  DATA_W  operands
- req_id  in  ID_W  requester tag, returned unchanged
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake
- rsp_code  out  2  calc2 response code as received
- rsp_data  out  DATA_W  calc2 result
- rsp_id  out  ID_W  ID of the originating request
- rsp_port  out  2  calc2 port used, 0..3 = port 1..4
- calc_cmd_out[1:4]  out  4 each  to calc2 reqN_cmd_in
- calc_data_out[1:4]  out  DATA_W each  to calc2 reqN_data_in
- calc_tag_out[1:4]  out  2 each  to calc2 reqN_tag_in
- calc_resp_in[1:4], calc_data_in[1:4], calc_tag_in[1:4]  in  2/DATA_W/2 each  from calc2 out_respN/out_dataN/out_tagN
- busy  out  1  any tag not FREE
- err_spurious  out  1  one-cycle pulse on unmatched response

## Operation
- Per port, per tag (16 total): state FREE -> ISSUED -> QUEUED -> FREE; ID table stores req_id.
- Per port, issue FSM: IDLE -> OP2 -> IDLE. IDLE with accepted request drives cmd, op1, tag; OP2 drives cmd=0, op2, tag=0. A port in OP2 is ineligible.
- Eligible port: issue FSM idle in the coming cycle and at least one FREE tag. Port is chosen round-robin starting after the last granted port; tag is the lowest-numbered FREE tag.
- req_ready = at least one eligible port (combinational from state only, not from req_valid).
- req_cmd=0: accepted (handshake completes), discarded, no calc2 traffic, no response.
- Response capture: calc_resp_inN != 0 in a cycle. If tag N/calc_tag_inN is ISSUED, push {code,data,tag} into port N 4-entry FIFO and mark tag QUEUED. Otherwise drop and pulse err_spurious. Up to 4 ports capture in the same cycle.
- Output arbiter: round-robin over non-empty port FIFOs, pointer advances past granted port only on handshake. On handshake pop the FIFO and set tag FREE. FIFO cannot overflow (at most 4 tags per port).
- rsp_* held stable while rsp_valid && !rsp_ready.

## Timing
- Reset values: req_ready 0 during reset, 1 the first cycle after; rsp_valid 0, rsp_* 0, all calc_*_out 0, busy 0, err_spurious 0; RR pointers to port 1; all tags FREE; FIFOs empty.
- Request handshake at edge N: calc cmd/op1/tag registered, visible cycle N+1; op2 cycle N+2; port eligible for a new command cycle N+3.
- Different ports overlap freely; at most one request accepted per cycle.
- Response captured at edge M: rsp_valid earliest cycle M+1 (registered output stage).
- Tag freed at rsp handshake edge K: reusable for a request accepted at edge K+1 (no same-cycle bypass).
- Reset mid-operation: all in-flight state discarded. Responses arriving after reset are spurious and flagged.
- Simultaneous capture and pop on the same FIFO: both take effect, count unchanged.

## Test plan
- Reset, single add 3+4 (id 0x11) -> port 1 sees cmd 1/data 3/tag 0 at N+1, data 4 at N+2; response 7, code 1, rsp_id 0x11, rsp_port 0.
- Four back-to-back requests, ids 1-4 -> dispatched to ports 1,2,3,4 in order, one per cycle; all four responses returned with matching IDs.
- 16 requests with rsp_ready=0 -> req_ready drops after 16th accepted, busy=1. Raise rsp_ready -> 16 responses drain, then req_ready=1 and busy=0.
- Responses on all four ports in the same cycle -> none lost; output order port 1,2,3,4 (pointer at reset value).
- Inject calc_resp_in2=1 with a FREE tag -> err_spurious pulses one cycle, no rsp_valid.
- Reset asserted between cmd and op2 cycles -> calc_*_out 0 the next cycle, busy 0. A later stale response is flagged spurious.
